// File: rtl/sys_ctrl_clk_rst_seq.sv
// sys_ctrl_clk_rst_seq: per-domain clock-enable/reset sequencer with boot address and HART_ID capture for core domains
module sys_ctrl_clk_rst_seq #(
  parameter int NUM_DOMAINS   = 5,
  parameter int NUM_CORES     = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic [NUM_DOMAINS-1:0][1:0]     ctrl_i,
  input  logic [NUM_CORES-1:0][31:0]      boot_addr_i,
  input  logic [NUM_CORES-1:0][31:0]      boot_hartid_i,
  output logic [NUM_DOMAINS-1:0]          dom_clk_en_o,
  output logic [NUM_DOMAINS-1:0]          dom_rst_no,
  output logic [NUM_CORES-1:0][31:0]      boot_addr_o,
  output logic [NUM_CORES-1:0][31:0]      boot_hartid_o,
  output logic [NUM_DOMAINS-1:0]          busy_o,
  output logic [NUM_DOMAINS-1:0]          stable_o
);
  localparam int MAX_CYC = SETTLE_CYCLES > DRAIN_CYCLES ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYCLES - 1);
  localparam logic [2:0] OFF   = 3'd0;
  localparam logic [2:0] WAKE  = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    logic [2:0]    state, nxt, tgt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          clk_en_q, rst_n_q, busy_q;
    assign tgt = !ctrl_i[d][0] ? OFF : ctrl_i[d][1] ? RUN : HOLD;
    always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      case (state)
        OFF:   if (tgt != OFF) begin nxt = WAKE; cnt_nxt = SETTLE_LD; end
        WAKE:  if (cnt != '0) cnt_nxt = cnt - 1'b1;
               else if (tgt == OFF) begin nxt = DRAIN; cnt_nxt = DRAIN_LD; end
               else nxt = tgt;
        HOLD:  if (tgt == RUN) nxt = RUN;
               else if (tgt == OFF) begin nxt = DRAIN; cnt_nxt = DRAIN_LD; end
        RUN:   if (tgt != RUN) begin nxt = DRAIN; cnt_nxt = DRAIN_LD; end
        DRAIN: if (cnt != '0) cnt_nxt = cnt - 1'b1;
               else nxt = tgt == OFF ? OFF : HOLD;
        default: begin nxt = OFF; cnt_nxt = '0; end
      endcase
    end
    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        state    <= OFF;
        cnt      <= '0;
        clk_en_q <= 1'b0;
        rst_n_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state    <= nxt;
        cnt      <= cnt_nxt;
        clk_en_q <= nxt != OFF;
        rst_n_q  <= nxt == RUN;
        busy_q   <= nxt == WAKE || nxt == DRAIN;
      end
    end
    assign dom_clk_en_o[d] = clk_en_q;
    assign dom_rst_no[d]   = rst_n_q;
    assign busy_o[d]       = busy_q;
    assign stable_o[d]     = state == tgt;
    if (d < NUM_CORES) begin : g_boot
      logic [31:0] addr_q, hart_q;
      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
          addr_q <= '0;
          hart_q <= '0;
        end else if (nxt == RUN && state != RUN) begin
          addr_q <= boot_addr_i[d];
          hart_q <= boot_hartid_i[d];
        end
      end
      assign boot_addr_o[d]   = addr_q;
      assign boot_hartid_o[d] = hart_q;
    end
  end
endmodule
